// File: rtl/instr_seq_ctrl.sv
// Phase sequencer for the single-cycle MIPS-subset datapath: turns CCLK into
// FETCH/EXEC/MEM/WB phases with halt, step, run and run-to-breakpoint modes.
module instr_seq_ctrl #(
  parameter int EXEC_WAIT = 2,
  parameter int DIV_W     = 24
) (
  input  logic             CCLK,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [DIV_W-1:0] run_div,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic [31:0]      next_pc,
  input  logic             mem_we_req,
  input  logic             reg_we_req,
  output logic             mem_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic             busy,
  output logic             halted,
  output logic             bp_hit,
  output logic [2:0]       state,
  output logic [31:0]      instr_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_BRK  = 2'b11;

  // EXEC counts down from EXEC_WAIT-1 so it occupies exactly EXEC_WAIT cycles.
  localparam logic [3:0] WAIT_LOAD = 4'(EXEC_WAIT - 1);

  state_t             state_reg, state_next;
  logic               step_q_reg;
  logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
  logic [3:0]         wait_cnt_reg, wait_cnt_next;
  logic [31:0]        instr_cnt_reg, instr_cnt_next;
  logic               halted_reg, halted_next;
  logic               bp_hit_reg, bp_hit_next;
  logic               step_edge;

  assign step_edge = step & ~step_q_reg;

  always_ff @(posedge CCLK) begin
    if (reset) begin
      state_reg     <= IDLE;
      step_q_reg    <= 1'b0;
      div_cnt_reg   <= '0;
      wait_cnt_reg  <= '0;
      instr_cnt_reg <= '0;
      halted_reg    <= 1'b0;
      bp_hit_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_q_reg    <= step;
      div_cnt_reg   <= div_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      instr_cnt_reg <= instr_cnt_next;
      halted_reg    <= halted_next;
      bp_hit_reg    <= bp_hit_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    div_cnt_next   = div_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    instr_cnt_next = instr_cnt_reg;
    halted_next    = halted_reg;
    bp_hit_next    = bp_hit_reg;

    case (state_reg)
      IDLE: begin
        case (mode)
          MODE_HALT: begin
            halted_next = 1'b0;
            bp_hit_next = 1'b0;
          end
          MODE_STEP: begin
            if (step_edge) state_next = FETCH;
          end
          default: begin
            // Run modes: the divider drains even while halted.
            if (div_cnt_reg != '0) begin
              div_cnt_next = div_cnt_reg - 1'b1;
            end else if (!halted_reg) begin
              if (mode == MODE_BRK && pc == bp_addr) begin
                halted_next = 1'b1;
                bp_hit_next = 1'b1;
              end else begin
                state_next = FETCH;
              end
            end
          end
        endcase
      end
      FETCH: begin
        state_next    = EXEC;
        wait_cnt_next = WAIT_LOAD;
      end
      EXEC: begin
        if (wait_cnt_reg == 4'd0) state_next = MEM;
        else wait_cnt_next = wait_cnt_reg - 4'd1;
      end
      MEM: state_next = WB;
      WB: begin
        state_next     = IDLE;
        instr_cnt_next = instr_cnt_reg + 32'd1;
        div_cnt_next   = run_div;
        // A branch/jump to itself can never make progress in run modes.
        if (mode[1] && next_pc == pc) halted_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_we    = (state_reg == MEM) & mem_we_req;
  assign reg_we    = (state_reg == WB) & reg_we_req;
  assign pc_we     = (state_reg == WB);
  assign busy      = (state_reg != IDLE);
  assign halted    = halted_reg;
  assign bp_hit    = bp_hit_reg;
  assign state     = state_reg;
  assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against an age-based behavioural model.
module tb_instr_seq_ctrl;
  localparam int EW    = 2;
  localparam int DIV_W = 24;

  logic             CCLK = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic             step = 1'b0;
  logic [DIV_W-1:0] run_div = '0;
  logic [31:0]      bp_addr = 32'hFFFF_FFF0;
  logic [31:0]      pc = 32'd0;
  logic [31:0]      next_pc;
  logic             mem_we_req = 1'b0;
  logic             reg_we_req = 1'b0;
  logic             mem_we, reg_we, pc_we, busy, halted, bp_hit;
  logic [2:0]       state;
  logic [31:0]      instr_cnt;

  logic             selfloop = 1'b0;
  logic [31:0]      wrap_mask = 32'hFFFF_FFFF;
  assign next_pc = selfloop ? pc : ((pc + 32'd4) & wrap_mask);

  instr_seq_ctrl #(.EXEC_WAIT(EW), .DIV_W(DIV_W)) dut (
    .CCLK(CCLK), .reset(reset), .mode(mode), .step(step), .run_div(run_div),
    .bp_addr(bp_addr), .pc(pc), .next_pc(next_pc), .mem_we_req(mem_we_req),
    .reg_we_req(reg_we_req), .mem_we(mem_we), .reg_we(reg_we), .pc_we(pc_we),
    .busy(busy), .halted(halted), .bp_hit(bp_hit), .state(state),
    .instr_cnt(instr_cnt)
  );

  always #5 CCLK = ~CCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: an instruction is described only by its age in cycles since the
  // start decision (0 = idle); phase follows from the age.
  int          m_k = 0;
  bit          m_stepq = 0, m_halted = 0, m_bp = 0;
  int unsigned m_div = 0;
  logic [31:0] m_cnt = 0;
  bit          pc_pend = 0;
  logic [31:0] pc_pend_val = 0;

  function automatic logic [2:0] age_state(input int k);
    if (k == 0) return 3'd0;
    if (k == 1) return 3'd1;
    if (k <= EW + 1) return 3'd2;
    if (k == EW + 2) return 3'd3;
    return 3'd4;
  endfunction

  always @(posedge CCLK) begin
    bit edge_v;
    if (m_k == EW + 3) begin
      pc_pend = 1;
      pc_pend_val = next_pc;
    end
    if (reset) begin
      m_k = 0; m_stepq = 0; m_div = 0; m_cnt = 0; m_halted = 0; m_bp = 0;
    end else begin
      edge_v = step && !m_stepq;
      if (m_k == 0) begin
        if (mode == 2'b00) begin
          m_halted = 0; m_bp = 0;
        end else if (mode == 2'b01) begin
          if (edge_v) m_k = 1;
        end else if (m_div != 0) begin
          m_div = m_div - 1;
        end else if (!m_halted) begin
          if (mode == 2'b11 && pc == bp_addr) begin
            m_halted = 1; m_bp = 1;
          end else m_k = 1;
        end
      end else if (m_k == EW + 3) begin
        m_cnt = m_cnt + 1;
        m_div = int'(run_div);
        if (mode[1] && next_pc == pc) m_halted = 1;
        m_k = 0;
      end else begin
        m_k = m_k + 1;
      end
      m_stepq = step;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CCLK) begin
    logic [2:0] ms;
    logic [63:0] exp_v, got_v;
    ms = age_state(m_k);
    exp_v = {24'd0, ms == 3'd3 && mem_we_req, ms == 3'd4 && reg_we_req, ms == 3'd4,
             m_k != 0, m_halted, m_bp, ms, m_cnt};
    got_v = {24'd0, mem_we, reg_we, pc_we, busy, halted, bp_hit, state, instr_cnt};
    chk("cycle_outputs", got_v, exp_v);
  end

  task automatic cyc();
    @(negedge CCLK);
    #1;
    if (pc_pend) begin
      pc = pc_pend_val;
      pc_pend = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    reset = 1; mode = 2'b00; step = 0; selfloop = 0;
    run(3);
    reset = 0; pc = 32'd0; pc_pend = 0;
  endtask

  initial begin
    logic [2:0] seq_exp [6];
    int last_f, gap_a, gap_b, nf, guard, pcwe_seen;
    seq_exp[0] = 3'd1; seq_exp[1] = 3'd2; seq_exp[2] = 3'd2;
    seq_exp[3] = 3'd3; seq_exp[4] = 3'd4; seq_exp[5] = 3'd0;

    // Reset defaults
    do_reset();
    run(20);
    chk("reset_state", state, 3'd0);
    chk("reset_flags", {busy, halted, bp_hit, mem_we, reg_we, pc_we}, 6'd0);
    chk("reset_cnt", instr_cnt, 32'd0);

    // Single step
    mode = 2'b01; reg_we_req = 1; mem_we_req = 0;
    step = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) step = 0;
      chk($sformatf("step_state%0d", i), state, seq_exp[i]);
      chk($sformatf("step_strobes%0d", i), {mem_we, reg_we, pc_we},
          {1'b0, seq_exp[i] == 3'd4, seq_exp[i] == 3'd4});
    end
    chk("step_cnt", instr_cnt, 32'd1);

    // Step filtering: held level, then a second edge during EXEC
    do_reset();
    mode = 2'b01;
    step = 1; run(50); step = 0;
    chk("hold_cnt", instr_cnt, 32'd1);
    run(5);
    step = 1; cyc(); step = 0; cyc();
    chk("in_exec", state, 3'd2);
    step = 1; cyc(); step = 0;
    run(12);
    chk("filter_cnt", instr_cnt, 32'd2);

    // Free run, run_div=3: starts spaced EW+4+3 = 9 cycles
    do_reset();
    mode = 2'b10; run_div = 3;
    last_f = -1; gap_a = 0; gap_b = 0; nf = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (state == 3'd1) begin
        if (nf == 1) gap_a = i - last_f;
        if (nf == 2) gap_b = i - last_f;
        last_f = i; nf++;
      end
    end
    chk("run_gap1", gap_a, 9);
    chk("run_gap2", gap_b, 9);
    chk("run_cnt100", instr_cnt, 32'd11);

    // Breakpoint at 0x0C
    do_reset();
    run_div = 0; bp_addr = 32'h0C; mode = 2'b11;
    run(60);
    chk("bp_cnt", instr_cnt, 32'd3);
    chk("bp_flags", {halted, bp_hit}, 2'b11);
    chk("bp_state", state, 3'd0);
    chk("bp_pc", pc, 32'h0C);
    mode = 2'b00; cyc();
    chk("bp_clear", {halted, bp_hit}, 2'b00);

    // Self-loop trap
    do_reset();
    bp_addr = 32'hFFFF_FFF0;
    pc = 32'h20; selfloop = 1; mode = 2'b10;
    run(20);
    chk("loop_flags", {halted, bp_hit}, 2'b10);
    chk("loop_cnt", instr_cnt, 32'd1);

    // Reset during MEM
    do_reset();
    mode = 2'b01; mem_we_req = 1;
    step = 1; cyc(); step = 0;
    guard = 0;
    while (state != 3'd3 && guard < 20) begin cyc(); guard++; end
    chk("reach_mem", state, 3'd3);
    chk("mem_strobe", mem_we, 1'b1);
    reset = 1; cyc(); reset = 0;
    chk("rst_state", state, 3'd0);
    chk("rst_cnt", instr_cnt, 32'd0);
    pcwe_seen = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (pc_we) pcwe_seen++; end
    chk("rst_no_wb", pcwe_seen, 0);

    // Randomized phase
    do_reset();
    wrap_mask = 32'h3C;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset = ($urandom % 250) == 0;
      if (m_k == 0 && ($urandom % 12) == 0) mode = 2'($urandom);
      if (($urandom % 3) == 0) step = ~step;
      run_div = DIV_W'($urandom % 4);
      if (($urandom % 40) == 0) bp_addr = ($urandom % 16) << 2;
      mem_we_req = 1'($urandom);
      reg_we_req = 1'($urandom);
      selfloop = ($urandom % 12) == 0;
    end
    reset = 0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
